// File: rtl/sca_mux_arb_if.sv
// Handshake bundle for the two-channel arbitrated mux: two producer channels,
// one registered consumer channel, and per-channel transfer counters.
interface sca_mux_arb_if #(
  parameter int SIZE = 1
);
  logic [SIZE-1:0] a_data;
  logic            a_valid;
  logic            a_ready;
  logic [SIZE-1:0] b_data;
  logic            b_valid;
  logic            b_ready;
  logic            sel;
  logic [SIZE-1:0] out;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      cnt_a;
  logic [7:0]      cnt_b;

  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, sel, out, out_valid, cnt_a, cnt_b
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, sel, out, out_valid, cnt_a, cnt_b
  );
endinterface

// File: rtl/sca_mux_arb.sv
// Two-channel round-robin arbiter feeding a one-word output register, with
// saturating per-channel transfer counters and the grant exported as SEL.
module sca_mux_arb #(
  parameter int SIZE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sca_mux_arb_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            last_q;
  logic            sel_p1;
  logic [SIZE-1:0] out_p1;
  logic [7:0]      cnt_a_q, cnt_b_q;

  logic            slot_free;
  logic            grant_a, grant_b;
  logic            xfer_a, xfer_b;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Grant/ready/next-state; rst_n gating keeps both READYs low during reset.
  always_comb begin
    state_d   = state_q;
    slot_free = (state_q == IDLE) || bus.out_ready;
    grant_a   = bus.a_valid && (!bus.b_valid || last_q);
    grant_b   = bus.b_valid && (!bus.a_valid || !last_q);
    xfer_a    = rst_n && slot_free && grant_a;
    xfer_b    = rst_n && slot_free && grant_b;
    if (xfer_a || xfer_b) begin
      state_d = FULL;
    end else if (bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage: word, grant and counters all update on the transfer edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1  <= '0;
      sel_p1  <= 1'b0;
      last_q  <= 1'b1;
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else if (xfer_a) begin
      out_p1  <= bus.a_data;
      sel_p1  <= 1'b0;
      last_q  <= 1'b0;
      cnt_a_q <= sat_inc(cnt_a_q);
    end else if (xfer_b) begin
      out_p1  <= bus.b_data;
      sel_p1  <= 1'b1;
      last_q  <= 1'b1;
      cnt_b_q <= sat_inc(cnt_b_q);
    end
  end

  assign bus.a_ready   = xfer_a;
  assign bus.b_ready   = xfer_b;
  assign bus.sel       = sel_p1;
  assign bus.out       = out_p1;
  assign bus.out_valid = (state_q == FULL);
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_sca_mux_arb.sv
// Bench for sca_mux_arb (SIZE=6): scenario tasks plus a scoreboard of expected
// output words, popped whenever the consumer takes OUT.
module tb_sca_mux_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sca_mux_arb_if #(.SIZE(6)) bus ();

  sca_mux_arb #(.SIZE(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected delivered words, in order
  logic [5:0] q_data[$];
  logic       q_sel[$];

  // Reference state of the arbiter
  bit         m_full;
  bit         m_last;
  bit         m_sel;
  logic [5:0] m_out;
  int         m_cnt_a;
  int         m_cnt_b;
  bit         exp_ar;
  bit         exp_br;

  task automatic model_reset();
    m_full  = 0;
    m_last  = 1;
    m_sel   = 0;
    m_out   = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    q_data.delete();
    q_sel.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies inputs, lets READY settle, and advances the reference model.
  task automatic drive(input bit av, input logic [5:0] ad, input bit bv,
                       input logic [5:0] bd, input bit ordy);
    bit slot;
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
    #1;
    slot   = !m_full || ordy;
    exp_ar = slot && av && (!bv || m_last);
    exp_br = slot && bv && (!av || !m_last);
    if (exp_ar) begin
      q_data.push_back(ad); q_sel.push_back(1'b0);
      m_out = ad; m_sel = 0; m_last = 0; m_full = 1;
      if (m_cnt_a < 255) m_cnt_a++;
    end else if (exp_br) begin
      q_data.push_back(bd); q_sel.push_back(1'b1);
      m_out = bd; m_sel = 1; m_last = 1; m_full = 1;
      if (m_cnt_b < 255) m_cnt_b++;
    end else if (ordy) begin
      m_full = 0;
    end
  endtask

  // Mid-cycle reset pulse
  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Scoreboard: every consumed word must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (q_data.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got out=%b sel=%b, required no delivery", bus.out, bus.sel);
      end else begin
        logic [5:0] ed;
        logic       es;
        ed = q_data.pop_front();
        es = q_sel.pop_front();
        if (bus.out !== ed || bus.sel !== es) begin
          failures++;
          $display("FAIL sb_word: got out=%b sel=%b, required out=%b sel=%b", bus.out, bus.sel, ed, es);
        end
      end
    end
  end

  task automatic test_reset();
    bus.a_valid = 1; bus.b_valid = 1; bus.out_ready = 1;
    bus.a_data = 6'b111111; bus.b_data = 6'b111111;
    #2;
    checks++;
    if (bus.out !== 6'd0 || bus.out_valid !== 1'b0 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: got out=%b vld=%b sel=%b, required 0/0/0", bus.out, bus.out_valid, bus.sel);
    end
    checks++;
    if (bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d, required 0/0", bus.cnt_a, bus.cnt_b);
    end
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got a=%b b=%b, required 0/0", bus.a_ready, bus.b_ready);
    end
    #5;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_a();
    drive(1, 6'b100100, 0, 6'd0, 1);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got a=%b b=%b, required 1/0", bus.a_ready, bus.b_ready);
    end
    tick();
    checks++;
    if (bus.out !== 6'b100100 || bus.sel !== 1'b0 || bus.out_valid !== 1'b1 || bus.cnt_a !== 8'd1) begin
      failures++;
      $display("FAIL single_out: got out=%b sel=%b vld=%b cnt_a=%0d, required 100100/0/1/1",
               bus.out, bus.sel, bus.out_valid, bus.cnt_a);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'b101100, 1, 6'b110111, 1);
      checks++;
      if (bus.a_ready !== ((i % 2) == 0) || bus.b_ready !== ((i % 2) == 1)) begin
        failures++;
        $display("FAIL alt_ready[%0d]: got a=%b b=%b, required a=%0d b=%0d",
                 i, bus.a_ready, bus.b_ready, (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      checks++;
      if (bus.sel !== 1'(i % 2) || bus.out !== (((i % 2) == 1) ? 6'b110111 : 6'b101100)) begin
        failures++;
        $display("FAIL alt_out[%0d]: got sel=%b out=%b, required sel=%0d", i, bus.sel, bus.out, i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'b000011, 1, 6'b001100, 0);
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready[%0d]: got a=%b b=%b, required 0/0", i, bus.a_ready, bus.b_ready);
      end
      tick();
      checks++;
      if (bus.out !== 6'b110111 || bus.sel !== 1'b1 || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got out=%b sel=%b vld=%b, required 110111/1/1",
                 i, bus.out, bus.sel, bus.out_valid);
      end
    end
    drive(1, 6'b000011, 1, 6'b001100, 1);
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_refill_ready: got a=%b b=%b, required 1/0", bus.a_ready, bus.b_ready);
    end
    tick();
    checks++;
    if (bus.out !== 6'b000011 || bus.sel !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_refill: got out=%b sel=%b vld=%b, required 000011/0/1", bus.out, bus.sel, bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      drive(0, 6'd0, 1, 6'(i), 1);
      checks++;
      if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
        failures++;
        $display("FAIL sat_ready[%0d]: got a=%b b=%b, required 0/1", i, bus.a_ready, bus.b_ready);
      end
      tick();
      checks++;
      if (bus.sel !== 1'b1 || bus.cnt_b !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        failures++;
        $display("FAIL sat_cnt[%0d]: got sel=%b cnt_b=%0d, required sel=1 cnt_b=%0d",
                 i, bus.sel, bus.cnt_b, (i + 1 > 255) ? 255 : i + 1);
      end
    end
    checks++;
    if (bus.cnt_b !== 8'd255 || bus.cnt_a !== 8'd0) begin
      failures++;
      $display("FAIL sat_final: got cnt_a=%0d cnt_b=%0d, required 0/255", bus.cnt_a, bus.cnt_b);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 6'b010111, 0, 6'd0, 1);
    tick();
    drive(1, 6'b000001, 1, 6'b000010, 0);
    checks++;
    if (bus.out !== 6'b010111 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre: got out=%b vld=%b, required 010111/1", bus.out, bus.out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 6'd0 || bus.out_valid !== 1'b0 || bus.sel !== 1'b0 ||
        bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
      failures++;
      $display("FAIL arst_clear: got out=%b vld=%b sel=%b cnt=%0d/%0d, required all 0",
               bus.out, bus.out_valid, bus.sel, bus.cnt_a, bus.cnt_b);
    end
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_ready: got a=%b b=%b, required 0/0", bus.a_ready, bus.b_ready);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_after_b();
    drive(0, 6'd0, 1, 6'b011001, 1);
    tick();
    checks++;
    if (bus.out !== 6'b011001 || bus.sel !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL idle_xfer: got out=%b sel=%b vld=%b, required 011001/1/1", bus.out, bus.sel, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 6'd0, 0, 6'd0, 1);
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ready[%0d]: got a=%b b=%b, required 0/0", i, bus.a_ready, bus.b_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== 6'b011001 || bus.sel !== 1'b1) begin
        failures++;
        $display("FAIL idle_hold[%0d]: got vld=%b out=%b sel=%b, required 0/011001/1",
                 i, bus.out_valid, bus.out, bus.sel);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), 6'($urandom),
            1'($urandom_range(0, 3) != 0));
      checks++;
      if (bus.a_ready !== exp_ar || bus.b_ready !== exp_br) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: got a=%b b=%b, required a=%b b=%b", i, bus.a_ready, bus.b_ready, exp_ar, exp_br);
      end
      tick();
      checks++;
      if (bus.out_valid !== m_full || bus.out !== m_out || bus.sel !== m_sel ||
          bus.cnt_a !== 8'(m_cnt_a) || bus.cnt_b !== 8'(m_cnt_b)) begin
        failures++;
        $display("FAIL rnd_state[%0d]: got vld=%b out=%b sel=%b cnt=%0d/%0d, required %b/%b/%b/%0d/%0d",
                 i, bus.out_valid, bus.out, bus.sel, bus.cnt_a, bus.cnt_b,
                 m_full, m_out, m_sel, m_cnt_a, m_cnt_b);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 6'd0, 0, 6'd0, 1);
      tick();
    end
    checks++;
    if (q_data.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: got %0d undelivered words, required 0", q_data.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 0;
    bus.a_data = '0; bus.b_data = '0;
    model_reset();
    test_reset();
    test_single_a();
    test_alternate();
    test_backpressure();
    test_saturate();
    test_async_reset();
    test_idle_after_b();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sca_mux_arb.md
SCA_MUX_ARB -- requirements
Module: sca_mux_arb

Interface
REQ-001 Parameter SHALL be: SIZE, default 1, width of each data channel and of OUT.
REQ-002 Port SHALL be: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port SHALL be: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: A_DATA  input  SIZE  channel-A data.
REQ-005 Port SHALL be: A_VALID  input  1  channel-A data valid.
REQ-006 Port SHALL be: A_READY  output  1  channel-A accepted this cycle when high with A_VALID.
REQ-007 Port SHALL be: B_DATA  input  SIZE  channel-B data.
REQ-008 Port SHALL be: B_VALID  input  1  channel-B data valid.
REQ-009 Port SHALL be: B_READY  output  1  channel-B accepted this cycle when high with B_VALID.
REQ-010 Port SHALL be: SEL  output  1  registered grant, drives the downstream sca_mux SEL (0 = A, 1 = B).
REQ-011 Port SHALL be: OUT  output  SIZE  registered selected data.
REQ-012 Port SHALL be: OUT_VALID  output  1  OUT holds an undelivered word.
REQ-013 Port SHALL be: OUT_READY  input  1  consumer takes OUT when high with OUT_VALID.
REQ-014 Port SHALL be: CNT_A  output  8  saturating count of channel-A transfers.
REQ-015 Port SHALL be: CNT_B  output  8  saturating count of channel-B transfers.

Function
REQ-016 Transfer on a channel SHALL occur on a rising CLK where its VALID and READY are both high.
REQ-017 FSM SHALL have two states: IDLE (OUT_VALID=0) and FULL (OUT_VALID=1).
REQ-018 Slot free SHALL be defined as IDLE, or FULL with OUT_READY=1 (same-cycle drain and refill).
REQ-019 Grant SHALL be: only A_VALID -> A; only B_VALID -> B; both -> channel opposite to LAST (internal reg, last granted channel); neither -> none.
REQ-020 A_READY SHALL equal slot free AND grant=A; B_READY SHALL equal slot free AND grant=B; both never high together.
REQ-021 READY outputs SHALL be combinational from VALIDs, OUT_READY, state and LAST, with no dependence on DATA.
REQ-022 On a transfer: OUT <= granted DATA, SEL <= grant, LAST <= grant, state -> FULL, all at the same edge (latency 1 cycle).
REQ-023 FULL with OUT_READY=1 and no new transfer SHALL go to IDLE; OUT and SEL hold their values.
REQ-024 FULL with OUT_READY=0 SHALL hold OUT, SEL, OUT_VALID unchanged; both READYs low.
REQ-025 IDLE with no VALID SHALL hold all registers.
REQ-026 Sustained throughput SHALL be one word per cycle when OUT_READY stays high.
REQ-027 CNT_A/CNT_B SHALL increment by 1 per transfer on their channel and saturate at 255 (no wrap).
REQ-028 VALID inputs at X/Z SHALL NOT be required to produce defined behaviour; the bench SHALL not depend on them.

Reset
REQ-029 RST_N low SHALL immediately force: OUT=0, OUT_VALID=0, SEL=0, LAST=1 (A wins first tie), CNT_A=0, CNT_B=0, state IDLE.
REQ-030 While RST_N is low, A_READY and B_READY SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard any held OUT word with no delivery.
REQ-032 First transfer after reset release SHALL be possible on the first rising CLK with RST_N high.

Verification (SIZE=6)
REQ-033 Reset, then A_VALID=1 A_DATA=100100, B_VALID=0, OUT_READY=1 -> A_READY=1; next edge OUT=100100, SEL=0, OUT_VALID=1, CNT_A=1.
REQ-034 Both valid each cycle, A_DATA=101100, B_DATA=110111, OUT_READY=1 -> grants alternate A,B,A,B from reset; SEL toggles 0,1,0,1; OUT alternates 101100/110111.
REQ-035 OUT_VALID=1 with OUT_READY=0 for 3 cycles, both VALIDs high -> both READYs 0, OUT and SEL constant; OUT_READY=1 -> drain and refill same edge, no bubble.
REQ-036 B-only stream of 260 words, OUT_READY=1 -> CNT_B=255 (saturated), CNT_A=0, SEL=1 throughout after first edge.
REQ-037 RST_N pulsed low asynchronously between edges while OUT_VALID=1 OUT=010111 -> OUT=0, OUT_VALID=0, SEL=0, counters 0 before next edge.
REQ-038 Idle (no VALID) after transfer of B_DATA=011001 with OUT_READY=1 -> OUT_VALID falls next edge, OUT stays 011001, SEL stays 1.
